// File: rtl/word_byte_bridge.sv
// Word<->byte-lane bridge: TX serialises handshaked words one lane per beat, RX packs bytes into auto-addressed word writes.
// TX: first byte 1 cycle after accept, holds under i_byte_ready=0, zero-bubble reload; RX: write strobe 1 cycle after final byte/flush, no backpressure.
module word_byte_bridge #(
    parameter int WORD_W    = 32,
    parameter int BYTE_W    = 8,
    parameter int ADDR_W    = 7,
    parameter int MSB_FIRST = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_word_valid,
    input  logic [WORD_W-1:0] i_word_data,
    output logic              o_word_ready,
    output logic              o_byte_valid,
    output logic [BYTE_W-1:0] o_byte_data,
    output logic              o_byte_last,
    input  logic              i_byte_ready,
    input  logic              i_rx_valid,
    input  logic [BYTE_W-1:0] i_rx_byte,
    input  logic              i_rx_flush,
    input  logic              i_rx_clear,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    output logic              o_rx_wrap
);
    localparam int LANES  = WORD_W / BYTE_W;
    localparam int LIDX_W = $clog2(LANES);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(LANES - 1);
    localparam logic [LIDX_W-1:0] ONE_L     = LIDX_W'(1);
    localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

    // ---------------- TX channel ----------------
    logic [0:0]        r_state;
    logic [LIDX_W-1:0] r_lane;
    logic [WORD_W-1:0] r_shadow;

    logic              w_shift;
    logic              w_last;
    logic              w_word_ready;
    logic              w_take;
    logic [LIDX_W-1:0] w_tx_sel;
    logic [BYTE_W-1:0] w_tx_lane [LANES];

    assign w_shift      = (r_state == ST_SHIFT);
    assign w_last       = (r_lane == LAST_LANE);
    assign w_word_ready = (r_state == ST_IDLE) || (w_shift && w_last && i_byte_ready);
    assign w_take       = i_word_valid && w_word_ready;
    assign w_tx_sel     = (MSB_FIRST != 0) ? (LAST_LANE - r_lane) : r_lane;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_tx_lane
        assign w_tx_lane[gi] = r_shadow[gi*BYTE_W +: BYTE_W];
    end

    // A word taken on the final beat reloads the shadow directly, so no idle cycle appears between words.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_lane   <= '0;
            r_shadow <= '0;
        end else if (w_take) begin
            r_state  <= ST_SHIFT;
            r_lane   <= '0;
            r_shadow <= i_word_data;
        end else if (w_shift && i_byte_ready) begin
            if (w_last) begin
                r_state <= ST_IDLE;
            end else begin
                r_lane <= r_lane + ONE_L;
            end
        end
    end

    assign o_word_ready = !i_rst && w_word_ready;
    assign o_byte_valid = !i_rst && w_shift;
    assign o_byte_data  = i_rst ? '0 : w_tx_lane[w_tx_sel];
    assign o_byte_last  = !i_rst && w_shift && w_last;

    // ---------------- RX channel ----------------
    logic [WORD_W-1:0] r_acc;
    logic [LIDX_W-1:0] r_cnt;
    logic [ADDR_W-1:0] r_waddr;
    logic              r_wrap;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [WORD_W-1:0] r_mem_wdata;

    logic [WORD_W-1:0] w_acc_nxt;
    logic [LIDX_W-1:0] w_pos;
    logic              w_full;
    logic              w_write;

    assign w_pos = (MSB_FIRST != 0) ? (LAST_LANE - r_cnt) : r_cnt;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_rx_lane
        assign w_acc_nxt[gi*BYTE_W +: BYTE_W] =
            (i_rx_valid && (w_pos == LIDX_W'(gi))) ? i_rx_byte : r_acc[gi*BYTE_W +: BYTE_W];
    end

    // The incoming byte counts toward both completion and the non-empty test for a flush.
    assign w_full  = i_rx_valid && (r_cnt == LAST_LANE);
    assign w_write = !i_rx_clear && (w_full || (i_rx_flush && (i_rx_valid || (r_cnt != '0))));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_waddr     <= '0;
            r_wrap      <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= w_write;
            if (i_rx_clear) begin
                r_acc   <= '0;
                r_cnt   <= '0;
                r_waddr <= '0;
                r_wrap  <= 1'b0;
            end else if (w_write) begin
                r_mem_wdata <= w_acc_nxt;
                r_mem_addr  <= r_waddr;
                r_waddr     <= r_waddr + ONE_A;
                if (&r_waddr) begin
                    r_wrap <= 1'b1;
                end
                r_acc <= '0;
                r_cnt <= '0;
            end else if (i_rx_valid) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + ONE_L;
            end
        end
    end

    assign o_mem_we    = !i_rst && r_mem_we;
    assign o_mem_addr  = i_rst ? '0 : r_mem_addr;
    assign o_mem_wdata = i_rst ? '0 : r_mem_wdata;
    assign o_rx_wrap   = !i_rst && r_wrap;

endmodule

// File: tb/tb_word_byte_bridge.sv
// Bench for word_byte_bridge: two instances (LSB-first/ADDR_W=2 and MSB-first/ADDR_W=7) share stimulus.
// Queue-based reference model feeds a scoreboard; a negedge monitor pops and compares.
module tb_word_byte_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic        word_valid;
    logic [31:0] word_data;
    logic        byte_ready;
    logic        rx_valid, rx_flush, rx_clear;
    logic [7:0]  rx_byte;

    logic        word_ready0, byte_valid0, byte_last0, mem_we0, wrap0;
    logic [7:0]  byte_data0;
    logic [1:0]  mem_addr0;
    logic [31:0] mem_wdata0;
    logic        word_ready1, byte_valid1, byte_last1, mem_we1, wrap1;
    logic [7:0]  byte_data1;
    logic [6:0]  mem_addr1;
    logic [31:0] mem_wdata1;

    always #5 clk = ~clk;

    word_byte_bridge #(.WORD_W(32), .BYTE_W(8), .ADDR_W(2), .MSB_FIRST(0)) u_lsb (
        .i_clk(clk), .i_rst(rst),
        .i_word_valid(word_valid), .i_word_data(word_data), .o_word_ready(word_ready0),
        .o_byte_valid(byte_valid0), .o_byte_data(byte_data0), .o_byte_last(byte_last0),
        .i_byte_ready(byte_ready),
        .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .i_rx_flush(rx_flush), .i_rx_clear(rx_clear),
        .o_mem_we(mem_we0), .o_mem_addr(mem_addr0), .o_mem_wdata(mem_wdata0), .o_rx_wrap(wrap0)
    );

    word_byte_bridge #(.WORD_W(32), .BYTE_W(8), .ADDR_W(7), .MSB_FIRST(1)) u_msb (
        .i_clk(clk), .i_rst(rst),
        .i_word_valid(word_valid), .i_word_data(word_data), .o_word_ready(word_ready1),
        .o_byte_valid(byte_valid1), .o_byte_data(byte_data1), .o_byte_last(byte_last1),
        .i_byte_ready(byte_ready),
        .i_rx_valid(rx_valid), .i_rx_byte(rx_byte), .i_rx_flush(rx_flush), .i_rx_clear(rx_clear),
        .o_mem_we(mem_we1), .o_mem_addr(mem_addr1), .o_mem_wdata(mem_wdata1), .o_rx_wrap(wrap1)
    );

    typedef struct { logic [7:0] b0; logic [7:0] b1; logic last; } tx_exp_t;
    typedef struct { logic [1:0] a0; logic [6:0] a1; logic [31:0] d0; logic [31:0] d1; int due; } wr_exp_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cycn    = 0;
    int          br_mode = 0;
    logic        tx_acc  = 1'b0;
    logic [31:0] tx_words[$];
    tx_exp_t     tq[$];
    wr_exp_t     wq[$];
    logic [7:0]  pend[$];
    int          waddr = 0;
    logic        exp_wrap0 = 1'b0;
    logic        exp_wrap1 = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycn);
        end
    endtask

    // One clock of RX stimulus; the model consumes it at the edge it is sampled on.
    task automatic cyc(input logic v, input logic [7:0] b, input logic f, input logic c);
        wr_exp_t e;
        rx_valid = v; rx_byte = b; rx_flush = f; rx_clear = c;
        if (rst) wq.delete();
        @(posedge clk);
        cycn++;
        if (rst || c) begin
            pend.delete();
            waddr = 0; exp_wrap0 = 1'b0; exp_wrap1 = 1'b0;
        end else begin
            if (v) pend.push_back(b);
            if (pend.size() == 4 || (f && pend.size() > 0)) begin
                e.d0 = '0; e.d1 = '0;
                foreach (pend[k]) begin
                    e.d0[8*k +: 8]     = pend[k];
                    e.d1[8*(3-k) +: 8] = pend[k];
                end
                e.a0 = 2'(waddr % 4);
                e.a1 = 7'(waddr % 128);
                e.due = cycn;
                wq.push_back(e);
                if (waddr % 4 == 3) exp_wrap0 = 1'b1;
                if (waddr % 128 == 127) exp_wrap1 = 1'b1;
                waddr++;
                pend.delete();
            end
        end
        #1;
    endtask

    task automatic drain();
        int i = 0;
        while ((tx_words.size() > 0 || tq.size() > 0) && i < 300) begin
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
            i++;
        end
        chk("tx_drain", 64'(tx_words.size() + tq.size()), 64'd0);
    endtask

    task automatic rx_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) cyc(1'b1, w[8*k +: 8], 1'b0, 1'b0);
    endtask

    // TX source: keeps word_valid/word_data stable until the handshake completes.
    initial begin
        word_valid = 1'b0; word_data = '0; byte_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tx_acc) void'(tx_words.pop_front());
            if (!word_valid || tx_acc)
                word_valid = (tx_words.size() > 0) && (br_mode != 2 || $urandom_range(3) != 0);
            word_data = (tx_words.size() > 0) ? tx_words[0] : 32'h0;
            byte_ready = (br_mode == 0) ? 1'b1 : (br_mode == 1) ? ~byte_ready : 1'($urandom_range(1));
        end
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_d0, prev_d1;
    logic       prev_l;

    always @(negedge clk) begin : mon
        tx_exp_t te;
        wr_exp_t e;
        logic    exp_we;
        if (rst) begin
            chk("rst_word_ready0", 64'(word_ready0), 64'd0);
            chk("rst_word_ready1", 64'(word_ready1), 64'd0);
            chk("rst_byte_valid0", 64'(byte_valid0), 64'd0);
            chk("rst_byte_valid1", 64'(byte_valid1), 64'd0);
            chk("rst_mem_we0", 64'(mem_we0), 64'd0);
            chk("rst_mem_we1", 64'(mem_we1), 64'd0);
            chk("rst_wrap0", 64'(wrap0), 64'd0);
            tq.delete();
            tx_acc = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("word_ready0", 64'(word_ready0), 64'(tq.size() == 0 || (tq.size() == 1 && byte_ready)));
            chk("word_ready1", 64'(word_ready1), 64'(tq.size() == 0 || (tq.size() == 1 && byte_ready)));
            chk("byte_valid0", 64'(byte_valid0), 64'(tq.size() > 0));
            chk("byte_valid1", 64'(byte_valid1), 64'(tq.size() > 0));
            if (prev_stall) begin
                chk("hold_data0", 64'(byte_data0), 64'(prev_d0));
                chk("hold_data1", 64'(byte_data1), 64'(prev_d1));
                chk("hold_last0", 64'(byte_last0), 64'(prev_l));
            end
            if (byte_valid0 && byte_ready && tq.size() > 0) begin
                te = tq.pop_front();
                chk("byte_data0", 64'(byte_data0), 64'(te.b0));
                chk("byte_data1", 64'(byte_data1), 64'(te.b1));
                chk("byte_last0", 64'(byte_last0), 64'(te.last));
                chk("byte_last1", 64'(byte_last1), 64'(te.last));
            end
            prev_stall = byte_valid0 && !byte_ready;
            prev_d0 = byte_data0; prev_d1 = byte_data1; prev_l = byte_last0;
            tx_acc = word_valid && word_ready0;
            if (tx_acc) begin
                for (int k = 0; k < 4; k++) begin
                    te.b0 = word_data[8*k +: 8];
                    te.b1 = word_data[8*(3-k) +: 8];
                    te.last = (k == 3);
                    tq.push_back(te);
                end
            end

            exp_we = (wq.size() > 0) && (wq[0].due == cycn);
            chk("mem_we0", 64'(mem_we0), 64'(exp_we));
            chk("mem_we1", 64'(mem_we1), 64'(exp_we));
            if (exp_we) begin
                e = wq.pop_front();
                chk("mem_addr0", 64'(mem_addr0), 64'(e.a0));
                chk("mem_addr1", 64'(mem_addr1), 64'(e.a1));
                chk("mem_wdata0", 64'(mem_wdata0), 64'(e.d0));
                chk("mem_wdata1", 64'(mem_wdata1), 64'(e.d1));
            end else if (wq.size() > 0 && wq[0].due < cycn) begin
                void'(wq.pop_front());
            end
            chk("rx_wrap0", 64'(wrap0), 64'(exp_wrap0));
            chk("rx_wrap1", 64'(wrap1), 64'(exp_wrap1));
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Single word, full-rate sink.
        br_mode = 0;
        tx_words.push_back(32'hA1B2C3D4);
        drain();

        // Back-to-back words, then the same pair under a toggling sink.
        tx_words.push_back(32'h11223344);
        tx_words.push_back(32'h55667788);
        drain();
        br_mode = 1;
        tx_words.push_back(32'h11223344);
        tx_words.push_back(32'h55667788);
        drain();
        br_mode = 0;

        // Two full RX words, then a partial flush and an empty flush.
        rx_word(32'hDEADBEEF);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rx_word(32'h01020304);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h12, 1'b0, 1'b0);
        cyc(1'b1, 8'h34, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Address wrap on the narrow instance, then clear racing a byte.
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        for (int w = 0; w < 5; w++) rx_word($urandom);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, 1'b1);
        rx_word(32'hCAFEF00D);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset while TX shifts and two RX bytes are pending.
        tx_words.push_back(32'h9ABCDEF0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        rx_word(32'h0BADC0DE);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        drain();

        // Randomised concurrent traffic on both channels.
        br_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (tx_words.size() < 3 && $urandom_range(3) == 0) tx_words.push_back($urandom);
            rst = ($urandom_range(499) == 0);
            cyc(1'($urandom_range(2) != 0), 8'($urandom), 1'($urandom_range(15) == 0),
                1'($urandom_range(63) == 0));
        end
        rst = 1'b0;
        br_mode = 0;
        drain();
        repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
